// File: rtl/bus_arbiter.sv
// bus_arbiter: two-master, one-slave arbiter with burst-limited sticky ownership,
// round-robin hand-over and registered routing of 1-cycle-latency read data.
module bus_arbiter #(
  parameter int WIDTH     = 32,
  parameter int MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_m0_req,
  input  logic [WIDTH-1:0] i_m0_addr,
  input  logic [WIDTH-1:0] i_m0_wdata,
  input  logic [3:0]       i_m0_be,
  input  logic             i_m0_we,
  output logic             o_m0_gnt,
  output logic             o_m0_rvalid,
  output logic [WIDTH-1:0] o_m0_rdata,
  input  logic             i_m1_req,
  input  logic [WIDTH-1:0] i_m1_addr,
  input  logic [WIDTH-1:0] i_m1_wdata,
  input  logic [3:0]       i_m1_be,
  input  logic             i_m1_we,
  output logic             o_m1_gnt,
  output logic             o_m1_rvalid,
  output logic [WIDTH-1:0] o_m1_rdata,
  output logic [WIDTH-1:0] o_s_addr,
  output logic [WIDTH-1:0] o_s_wdata,
  output logic [3:0]       o_s_be,
  output logic             o_s_we,
  input  logic [WIDTH-1:0] i_s_rdata
);
  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;
  localparam logic [3:0] MB = 4'(MAX_BURST);
  state_t     r_state, w_state_nxt;
  logic [3:0] r_cnt, w_cnt_nxt;
  logic       r_last, w_last_nxt;
  logic       r_pend, r_pend_id;
  logic       w_keep, w_g0, w_g1, w_any, w_same;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_last    <= 1'b1;
      r_pend    <= 1'b0;
      r_pend_id <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_last    <= w_last_nxt;
      r_pend    <= w_any & ~o_s_we;
      r_pend_id <= w_g1;
    end
  always_comb begin
    w_same      = (r_state == OWN0 && w_g0) || (r_state == OWN1 && w_g1);
    w_state_nxt = w_g0 ? OWN0 : w_g1 ? OWN1 : IDLE;
    w_cnt_nxt   = !w_any ? 4'd0 : !w_same ? 4'd1 : r_cnt >= MB ? MB : r_cnt + 4'd1;
    w_last_nxt  = w_any ? w_g1 : r_last;
  end
  // The owner keeps the bus until its burst budget runs out while the other master waits
  always_comb begin
    w_keep      = r_state == OWN1 ? i_m1_req && (!i_m0_req || r_cnt < MB)
                                  : i_m0_req && (!i_m1_req || r_cnt < MB);
    w_g0        = !rst && (r_state == OWN0 ? w_keep
                         : r_state == OWN1 ? !w_keep && i_m0_req
                         : i_m0_req && !(i_m1_req && !r_last));
    w_g1        = !rst && (r_state == OWN1 ? w_keep
                         : r_state == OWN0 ? !w_keep && i_m1_req
                         : i_m1_req && !(i_m0_req && r_last));
    w_any       = w_g0 | w_g1;
    o_m0_gnt    = w_g0;
    o_m1_gnt    = w_g1;
    o_s_addr    = w_g0 ? i_m0_addr  : w_g1 ? i_m1_addr  : '0;
    o_s_wdata   = w_g0 ? i_m0_wdata : w_g1 ? i_m1_wdata : '0;
    o_s_be      = w_g0 ? i_m0_be    : w_g1 ? i_m1_be    : 4'd0;
    o_s_we      = w_g0 ? i_m0_we    : w_g1 & i_m1_we;
    o_m0_rvalid = r_pend & ~r_pend_id;
    o_m1_rvalid = r_pend & r_pend_id;
    o_m0_rdata  = o_m0_rvalid ? i_s_rdata : '0;
    o_m1_rdata  = o_m1_rvalid ? i_s_rdata : '0;
  end
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed and randomized checks of bus_arbiter against a
// transaction-level reference model and a byte-enabled RAM model.
module tb_bus_arbiter;
  localparam int MB = 4;
  logic        clk = 1'b0, rst, load;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [3:0]  m0_be, m1_be;
  logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, s_we;
  logic [31:0] m0_rdata, m1_rdata, s_addr, s_wdata, s_rdata;
  logic [3:0]  s_be;
  logic [31:0] ram [16];
  logic [31:0] rmem [16];
  int          n_tests = 0, n_fail = 0;
  int          owner, run, last, last_g;
  logic        ev0, ev1;
  logic [31:0] edata;

  always #5 clk = ~clk;

  bus_arbiter #(.WIDTH(32), .MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst),
    .i_m0_req(m0_req), .i_m0_addr(m0_addr), .i_m0_wdata(m0_wdata), .i_m0_be(m0_be),
    .i_m0_we(m0_we), .o_m0_gnt(m0_gnt), .o_m0_rvalid(m0_rvalid), .o_m0_rdata(m0_rdata),
    .i_m1_req(m1_req), .i_m1_addr(m1_addr), .i_m1_wdata(m1_wdata), .i_m1_be(m1_be),
    .i_m1_we(m1_we), .o_m1_gnt(m1_gnt), .o_m1_rvalid(m1_rvalid), .o_m1_rdata(m1_rdata),
    .o_s_addr(s_addr), .o_s_wdata(s_wdata), .o_s_be(s_be), .o_s_we(s_we), .i_s_rdata(s_rdata)
  );

  function automatic logic [31:0] init_word(input int i);
    return i == 4 ? 32'hDEADBEEF : 32'h11111111 * i;
  endfunction

  always @(posedge clk)
    if (load)
      for (int i = 0; i < 16; i++) ram[i] <= init_word(i);
    else begin
      if (s_we)
        for (int b = 0; b < 4; b++)
          if (s_be[b]) ram[s_addr[5:2]][8*b+:8] <= s_wdata[8*b+:8];
      s_rdata <= ram[s_addr[5:2]];
    end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset;
    owner = -1; run = 0; last = 1; last_g = -1; ev0 = 0; ev1 = 0; edata = '0;
  endtask

  // One bus cycle: entered just after a falling edge with inputs applied, leaves at the next one
  task automatic step;
    int g, o, idx;
    logic rq[2], wq[2];
    logic [31:0] aq[2], dq[2];
    logic [3:0] bq[2];
    rq[0] = m0_req; wq[0] = m0_we; aq[0] = m0_addr; dq[0] = m0_wdata; bq[0] = m0_be;
    rq[1] = m1_req; wq[1] = m1_we; aq[1] = m1_addr; dq[1] = m1_wdata; bq[1] = m1_be;
    #1;
    g = -1;
    if (owner < 0) begin
      if (rq[0] && rq[1]) g = 1 - last;
      else if (rq[0]) g = 0;
      else if (rq[1]) g = 1;
    end else begin
      o = 1 - owner;
      if (rq[owner] && (!rq[o] || run < MB)) g = owner;
      else if (rq[o]) g = o;
    end
    check("m0_gnt", m0_gnt, g == 0);
    check("m1_gnt", m1_gnt, g == 1);
    check("mutex", m0_gnt & m1_gnt, 0);
    check("s_we", s_we, g >= 0 ? wq[g] : 1'b0);
    check("s_addr", s_addr, g >= 0 ? aq[g] : 32'd0);
    check("s_wdata", s_wdata, g >= 0 ? dq[g] : 32'd0);
    check("s_be", s_be, g >= 0 ? bq[g] : 4'd0);
    check("m0_rvalid", m0_rvalid, ev0);
    check("m1_rvalid", m1_rvalid, ev1);
    check("m0_rdata", m0_rdata, ev0 ? edata : 32'd0);
    check("m1_rdata", m1_rdata, ev1 ? edata : 32'd0);
    ev0 = g == 0 && !wq[0];
    ev1 = g == 1 && !wq[1];
    if (g >= 0) begin
      idx = int'(aq[g][5:2]);
      if (!wq[g]) edata = rmem[idx];
      else
        for (int b = 0; b < 4; b++)
          if (bq[g][b]) rmem[idx][8*b+:8] = dq[g][8*b+:8];
      run  = g == owner ? (run < MB ? run + 1 : MB) : 1;
      last = g;
    end else run = 0;
    owner  = g;
    last_g = g;
    @(negedge clk);
  endtask

  task automatic idle_bus;
    m0_req = 0; m1_req = 0; m0_we = 0; m1_we = 0;
    m0_addr = '0; m1_addr = '0; m0_wdata = '0; m1_wdata = '0; m0_be = '0; m1_be = '0;
  endtask

  task automatic do_reset;
    idle_bus();
    rst = 1;
    #1;
    check("rst_gnt", {m0_gnt, m1_gnt}, 0);
    check("rst_rvalid", {m0_rvalid, m1_rvalid}, 0);
    @(negedge clk);
    rst = 0;
    model_reset();
  endtask

  initial begin
    logic [11:0] pat;
    pat = 12'b0000_1111_0000;
    for (int i = 0; i < 16; i++) rmem[i] = init_word(i);
    idle_bus();
    model_reset();
    rst = 1; load = 1;
    m0_req = 1; m1_req = 1; m0_we = 1; m1_we = 1; m0_be = 4'hf; m1_be = 4'hf;
    @(negedge clk);
    #1;
    check("rst_gated_gnt", {m0_gnt, m1_gnt}, 0);
    check("rst_s_we", s_we, 0);
    check("rst_s_be", s_be, 0);
    check("rst_s_addr", s_addr, 0);
    @(negedge clk);
    load = 0;
    do_reset();
    // m0 read of the DEADBEEF word
    m0_req = 1; m0_addr = 32'h10; m0_be = 4'hf;
    #1;
    check("t1_gnt", m0_gnt, 1);
    check("t1_saddr", s_addr, 32'h10);
    step();
    m0_req = 0;
    #1;
    check("t1_rvalid", m0_rvalid, 1);
    check("t1_rdata", m0_rdata, 32'hDEADBEEF);
    check("t1_m1_rvalid", m1_rvalid, 0);
    step();
    // tie after idle following an m0 transfer goes to m1
    m0_req = 1; m1_req = 1; m0_addr = 32'h4; m1_addr = 32'h8;
    #1;
    check("tie_last0", m1_gnt, 1);
    step();
    idle_bus();
    step();
    // m1 partial write, then m0 reads the merged word back
    m1_req = 1; m1_we = 1; m1_addr = 32'h20; m1_wdata = 32'h0000A5A5; m1_be = 4'b0011;
    #1;
    check("wr_s_we", s_we, 1);
    check("wr_s_be", s_be, 4'b0011);
    step();
    idle_bus();
    m0_req = 1; m0_addr = 32'h20; m0_be = 4'hf;
    #1;
    check("wr_no_rvalid", {m0_rvalid, m1_rvalid}, 0);
    step();
    idle_bus();
    #1;
    check("rb_rvalid", m0_rvalid, 1);
    check("rb_rdata", m0_rdata, 32'h8888A5A5);
    step();
    // continuous contention from a fresh reset
    do_reset();
    m0_req = 1; m1_req = 1; m0_addr = 32'h0; m1_addr = 32'h3c;
    for (int i = 0; i < 12; i++) begin
      #1;
      check("burst_m1", m1_gnt, pat[i]);
      check("burst_m0", m0_gnt, !pat[i]);
      step();
    end
    idle_bus();
    step();
    // reset right after a granted m1 read drops the return
    m1_req = 1; m1_addr = 32'h30;
    #1;
    check("mid_gnt", m1_gnt, 1);
    @(posedge clk);
    rst = 1;
    #1;
    check("mid_rvalid", m1_rvalid, 0);
    check("mid_s_we", s_we, 0);
    check("mid_s_addr", s_addr, 0);
    check("mid_s_be", s_be, 0);
    check("mid_gnt_rst", m1_gnt, 0);
    model_reset();
    @(negedge clk);
    rst = 0;
    step();
    m1_req = 0;
    step();
    // random traffic, each request held until granted
    for (int c = 0; c < 600; c++) begin
      if (!m0_req || last_g == 0) begin
        m0_req = 1'($urandom_range(0, 2) != 0); m0_we = 1'($urandom);
        m0_addr = {26'd0, 4'($urandom), 2'b00}; m0_wdata = $urandom; m0_be = 4'($urandom);
      end
      if (!m1_req || last_g == 1) begin
        m1_req = 1'($urandom_range(0, 2) != 0); m1_we = 1'($urandom);
        m1_addr = {26'd0, 4'($urandom), 2'b00}; m1_wdata = $urandom; m1_be = 4'($urandom);
      end
      step();
    end
    idle_bus();
    step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Two-master, one-slave arbiter that shares the on-chip memory port (RAM behind `bus_interconnect`) between `rysy_core` (master 0) and a second bus master such as a program loader or DMA engine (master 1). Grants are made per transfer. Ownership is sticky for up to `MAX_BURST` back-to-back transfers, then rotates round-robin when the other master is waiting. The block registers read-return routing so each master receives its own 1-cycle-latency synchronous-RAM read data.

## Interface
- `WIDTH`, 32, data and address width.
- `MAX_BURST`, 4, maximum consecutive transfers one master may hold while the other requests; legal range is 1..15.
- `clk` input 1: single clock. All state updates on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `m0_req`, `m1_req` input 1: transfer request, held until granted.
- `m0_addr`, `m1_addr` input WIDTH: byte address.
- `m0_wdata`, `m1_wdata` input WIDTH: write data.
- `m0_be`, `m1_be` input 4: byte enables.
- `m0_we`, `m1_we` input 1: 1 = write, 0 = read.
- `m0_gnt`, `m1_gnt` output 1: transfer accepted this cycle. This output is combinational.
- `m0_rvalid`, `m1_rvalid` output 1: read data valid. This output is registered.
- `m0_rdata`, `m1_rdata` output WIDTH: read data, meaningful only while `rvalid` is high.
- `s_addr`, `s_wdata` output WIDTH: slave address and write data.
- `s_be` output 4: slave byte enables.
- `s_we` output 1: slave write enable.
- `s_rdata` input WIDTH: slave read data, valid one cycle after the read address is presented.

## Operation
- State is {IDLE, OWN0, OWN1}, plus a burst counter `cnt` (4 bits, saturating at `MAX_BURST`) and a `last` pointer (the last granted master).
- Grant decision is combinational each cycle. x denotes the owner and y the other master.
  - IDLE:
    - Both requesting: grant the master that is not `last`.
    - One requesting: grant that master.
    - None requesting: no grant.
  - OWNx:
    - If mx_req and (!my_req or cnt < MAX_BURST): grant x.
    - Else if my_req: grant y.
    - Else: no grant.
- Next state:
  - Grant to g: state becomes OWNg and `last` becomes g.
  - `cnt` becomes min(cnt+1, MAX_BURST) if g equals the previous owner, otherwise 1.
  - No grant: state becomes IDLE, `cnt` becomes 0, and `last` is unchanged.
- Slave mux:
  - While a grant is active, the `s_*` outputs carry the granted master's `addr/wdata/be/we`.
  - With no grant, `s_we`=0, `s_be`=0, `s_addr`=0, `s_wdata`=0. A write to the slave never occurs without a grant.
- Read return:
  - A granted read (`we`=0) sets a 1-bit pending tag (master id) and asserts that master's `rvalid` in the next cycle.
  - `mX_rdata` = `s_rdata` while `mX_rvalid`=1, else 0.
  - Writes produce no `rvalid`.
- Simultaneous events:
  - A read return and a new grant in the same cycle are independent. Throughput is one transfer per cycle with no bubbles, including at an ownership switch.
- Unrequesting masters never receive a grant. Both `gnt` signals are never high together.

## Timing
- Reset (async assert):
  - state=IDLE, `cnt`=0, `last`=1 (master 0 wins the first tie), pending cleared, both `rvalid`=0.
  - Both `gnt` and all `s_*` outputs are forced to 0 while `rst`=1.
- Grant latency: 0 cycles. `gnt` is high in the same cycle `req` is seen if arbitration allows.
- Read latency: `rvalid` and `rdata` are high exactly 1 cycle after the granted read cycle, for one cycle per transfer.
- Reset mid-operation: an outstanding read return is dropped and no `rvalid` follows reset release. The first cycle after release arbitrates from IDLE.
- Fairness: with both masters continuously requesting, each gets exactly `MAX_BURST` consecutive grants, alternating.
- `MAX_BURST`=1 gives strict alternation under contention.

## Test plan
- Reset release, then `m0_req`=1 read of addr 0x10, RAM word 0xDEADBEEF:
  - `m0_gnt`=1 in the same cycle and `s_addr`=0x10.
  - Next cycle `m0_rvalid`=1 and `m0_rdata`=0xDEADBEEF; `m1_rvalid`=0.
- Both masters request continuously, `MAX_BURST`=4:
  - Grant sequence is 0,0,0,0,1,1,1,1,0,… with no idle cycles.
- Tie from IDLE after reset: master 0 is granted first. Tie after idle following a master-0 transfer: master 1 is granted.
- m1 writes 0x0000A5A5 with `be`=0011 to 0x20 while m0 is idle; m0 then reads 0x20:
  - One `s_we` pulse with `s_be`=0011 during the write.
  - m0 reads back the merged word. No `rvalid` follows the write.
- Assert `rst` in the cycle after a granted m1 read:
  - `m1_rvalid` stays 0 and all `s_*` outputs are 0.
  - After release, a pending m1 request is granted from IDLE.
- Random req/we/addr from both masters against a reference model:
  - Never are both `gnt` signals high at once.
  - `s_we`=0 whenever no grant is active.
  - Every read returns to the requesting master with the correct data.
